// File: rtl/dht11_pkg.sv
// dht11_pkg: shared types, sensor limits and helpers for the DHT11 sample controller.
package dht11_pkg;
  localparam int SENS_W = 8;
  localparam int TEMP_MAX = 50;
  localparam int HUM_MAX = 95;
  typedef logic [SENS_W-1:0] sens_t;
  typedef enum logic [2:0] {
    ST_WARMUP,
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RDY,
    ST_CAPTURE,
    ST_GAP
  } state_t;
  function automatic sens_t sat_inc(input sens_t v);
    return (v == '1) ? v : v + sens_t'(1);
  endfunction
  function automatic logic hyst(input logic cur, input sens_t v, input sens_t hi, input sens_t lo);
    return (v >= hi) ? 1'b1 : (v <= lo) ? 1'b0 : cur;
  endfunction
endpackage

// File: rtl/dht11_avg_ch.sv
// dht11_avg_ch: moving average over a ring of samples; shows the latest raw sample until full.
module dht11_avg_ch
  import dht11_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  sens_t din,
  output sens_t dout,
  output logic  full
);
  localparam int DEPTH = 2 ** AVG_LOG2;
  localparam int SUM_W = SENS_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  sens_t ring_q [DEPTH];
  sens_t ring_d [DEPTH];
  logic [AVG_LOG2-1:0] wp_q, wp_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  sens_t last_q, last_d;
  assign full = fill_q == FILL_W'(DEPTH);
  assign dout = full ? sens_t'(sum_q >> AVG_LOG2) : last_q;
  // the slot at wp_q holds the oldest sample, so it leaves the sum as din enters
  always_comb begin
    ring_d = ring_q;
    ring_d[wp_q] = push ? din : ring_q[wp_q];
    wp_d = push ? wp_q + AVG_LOG2'(1) : wp_q;
    sum_d = push ? sum_q + SUM_W'(din) - SUM_W'(ring_q[wp_q]) : sum_q;
    fill_d = (push && !full) ? fill_q + FILL_W'(1) : fill_q;
    last_d = push ? din : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_q <= '{default: '0};
      wp_q <= '0;
      fill_q <= '0;
      sum_q <= '0;
      last_q <= '0;
    end else begin
      ring_q <= ring_d;
      wp_q <= wp_d;
      fill_q <= fill_d;
      sum_q <= sum_d;
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/dht11_sample_ctrl.sv
// dht11_sample_ctrl: periodic DHT11 request sequencer with range check, averaging,
// hysteresis alarms and timeout/error accounting.
module dht11_sample_ctrl
  import dht11_pkg::*;
#(
  parameter int WARMUP_CYC = 60_000_000,
  parameter int PERIOD_CYC = 100_000_000,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int EN_CYC = 16,
  parameter int AVG_LOG2 = 2,
  parameter int T_HI = 35,
  parameter int T_LO = 30,
  parameter int H_HI = 80,
  parameter int H_LO = 70
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       dht_sample_en,
  input  logic       dht_data_rdy,
  input  logic [7:0] dht_temperature,
  input  logic [7:0] dht_humidity,
  output logic [7:0] temp_out,
  output logic [7:0] hum_out,
  output logic       avg_valid,
  output logic       new_sample,
  output logic       temp_alarm,
  output logic       hum_alarm,
  output logic       timeout_err,
  output logic [7:0] err_cnt
);
  localparam int TMAX = (WARMUP_CYC > PERIOD_CYC) ? WARMUP_CYC : PERIOD_CYC;
  localparam int TW = $clog2(TMAX + 1);
  typedef logic [TW-1:0] tmr_t;
  state_t st_q, st_d;
  tmr_t tmr_q, tmr_d;
  logic rdy_q, se_q, se_d, push_q, push_d, new_q, new_d, valid_q, valid_d;
  logic talm_q, talm_d, halm_q, halm_d, tout_q, tout_d;
  sens_t cap_t_q, cap_t_d, cap_h_q, cap_h_d, temp_q, temp_d, hum_q, hum_d, err_q, err_d;
  sens_t avg_t, avg_h;
  logic full_t, full_h, rdy_edge, tmo, in_range;
  assign rdy_edge = dht_data_rdy & ~rdy_q;
  assign tmo = tmr_q >= tmr_t'(TIMEOUT_CYC - 1);
  assign in_range = (cap_t_q <= sens_t'(TEMP_MAX)) && (cap_h_q <= sens_t'(HUM_MAX));
  assign dht_sample_en = se_q;
  assign temp_out = temp_q;
  assign hum_out = hum_q;
  assign avg_valid = valid_q;
  assign new_sample = new_q;
  assign temp_alarm = talm_q;
  assign hum_alarm = halm_q;
  assign timeout_err = tout_q;
  assign err_cnt = err_q;
  dht11_avg_ch #(.AVG_LOG2(AVG_LOG2)) u_avg_t (
    .clk(clk), .rst_n(rst_n), .push(push_d), .din(cap_t_q), .dout(avg_t), .full(full_t)
  );
  dht11_avg_ch #(.AVG_LOG2(AVG_LOG2)) u_avg_h (
    .clk(clk), .rst_n(rst_n), .push(push_d), .din(cap_h_q), .dout(avg_h), .full(full_h)
  );
  // one timer serves warm-up, the enable pulse width, the timeout and the period
  always_comb begin
    st_d = st_q;
    tmr_d = tmr_q + tmr_t'(1);
    se_d = 1'b0;
    push_d = 1'b0;
    new_d = push_q;
    cap_t_d = cap_t_q;
    cap_h_d = cap_h_q;
    err_d = err_q;
    tout_d = tout_q;
    temp_d = push_q ? avg_t : temp_q;
    hum_d = push_q ? avg_h : hum_q;
    valid_d = push_q ? (full_t & full_h) : valid_q;
    talm_d = new_q ? hyst(talm_q, temp_q, sens_t'(T_HI), sens_t'(T_LO)) : talm_q;
    halm_d = new_q ? hyst(halm_q, hum_q, sens_t'(H_HI), sens_t'(H_LO)) : halm_q;
    case (st_q)
      ST_WARMUP: st_d = (tmr_q == tmr_t'(WARMUP_CYC - 1)) ? ST_IDLE : ST_WARMUP;
      ST_IDLE: begin
        st_d = enable ? ST_TRIG : ST_IDLE;
        tmr_d = '0;
        se_d = enable;
      end
      ST_TRIG: begin
        st_d = !enable ? ST_IDLE : (tmr_q == tmr_t'(EN_CYC - 1)) ? ST_WAIT_RDY : ST_TRIG;
        se_d = enable && (tmr_q != tmr_t'(EN_CYC - 1));
      end
      ST_WAIT_RDY: begin
        st_d = (rdy_edge || tmo) ? (rdy_edge ? ST_CAPTURE : ST_GAP) : ST_WAIT_RDY;
        cap_t_d = rdy_edge ? dht_temperature : cap_t_q;
        cap_h_d = rdy_edge ? dht_humidity : cap_h_q;
        tout_d = (!rdy_edge && tmo) ? 1'b1 : tout_q;
        err_d = (!rdy_edge && tmo) ? sat_inc(err_q) : err_q;
      end
      ST_CAPTURE: begin
        st_d = ST_GAP;
        push_d = in_range;
        tout_d = in_range ? 1'b0 : tout_q;
        err_d = in_range ? err_q : sat_inc(err_q);
      end
      ST_GAP: begin
        st_d = !enable ? ST_IDLE : (tmr_q == tmr_t'(PERIOD_CYC - 1)) ? ST_TRIG : ST_GAP;
        tmr_d = (st_d == ST_TRIG) ? '0 : tmr_q + tmr_t'(1);
        se_d = st_d == ST_TRIG;
      end
      default: st_d = ST_WARMUP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ST_WARMUP;
      tmr_q <= '0;
      rdy_q <= 1'b0;
      se_q <= 1'b0;
      push_q <= 1'b0;
      new_q <= 1'b0;
      valid_q <= 1'b0;
      talm_q <= 1'b0;
      halm_q <= 1'b0;
      tout_q <= 1'b0;
      cap_t_q <= '0;
      cap_h_q <= '0;
      temp_q <= '0;
      hum_q <= '0;
      err_q <= '0;
    end else begin
      st_q <= st_d;
      tmr_q <= tmr_d;
      rdy_q <= dht_data_rdy;
      se_q <= se_d;
      push_q <= push_d;
      new_q <= new_d;
      valid_q <= valid_d;
      talm_q <= talm_d;
      halm_q <= halm_d;
      tout_q <= tout_d;
      cap_t_q <= cap_t_d;
      cap_h_q <= cap_h_d;
      temp_q <= temp_d;
      hum_q <= hum_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_dht11_sample_ctrl.sv
// tb_dht11_sample_ctrl: directed bench for the DHT11 sample controller with reduced timing.
module tb_dht11_sample_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic dht_data_rdy = 1'b0;
  logic [7:0] dht_temperature = '0;
  logic [7:0] dht_humidity = '0;
  logic dht_sample_en, avg_valid, new_sample, temp_alarm, hum_alarm, timeout_err;
  logic [7:0] temp_out, hum_out, err_cnt;
  int tests = 0;
  int fails = 0;
  int cyc;
  int r;
  int w;
  bit seen;

  dht11_sample_ctrl #(
    .WARMUP_CYC(100), .PERIOD_CYC(400), .TIMEOUT_CYC(200), .EN_CYC(4), .AVG_LOG2(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dht_sample_en(dht_sample_en),
    .dht_data_rdy(dht_data_rdy), .dht_temperature(dht_temperature), .dht_humidity(dht_humidity),
    .temp_out(temp_out), .hum_out(hum_out), .avg_valid(avg_valid), .new_sample(new_sample),
    .temp_alarm(temp_alarm), .hum_alarm(hum_alarm), .timeout_err(timeout_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // posedges since reset release
  always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_se(output int rc);
    int n = 0;
    while (dht_sample_en !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("se_rise_wait", 32'(n < 2000), 1);
    rc = cyc;
  endtask

  task automatic wait_fall();
    int n = 0;
    while (dht_sample_en !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("se_fall_wait", 32'(n < 50), 1);
  endtask

  task automatic answer(input string s, input int t, input int h, input bit ok, input int et,
                        input int eh, input bit ev, input bit eta, input bit eha, input int ee);
    wait_fall();
    dht_data_rdy = 1'b1;
    dht_temperature = 8'(t);
    dht_humidity = 8'(h);
    @(negedge clk);
    dht_data_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk($sformatf("%s.new_sample", s), 32'(new_sample), int'(ok));
    chk($sformatf("%s.temp_out", s), 32'(temp_out), et);
    chk($sformatf("%s.hum_out", s), 32'(hum_out), eh);
    chk($sformatf("%s.avg_valid", s), 32'(avg_valid), int'(ev));
    chk($sformatf("%s.err_cnt", s), 32'(err_cnt), ee);
    chk($sformatf("%s.timeout_err", s), 32'(timeout_err), 0);
    @(negedge clk);
    chk($sformatf("%s.new_sample_drop", s), 32'(new_sample), 0);
    chk($sformatf("%s.temp_alarm", s), 32'(temp_alarm), int'(eta));
    chk($sformatf("%s.hum_alarm", s), 32'(hum_alarm), int'(eha));
  endtask

  task automatic req(input string s, input int t, input int h, input bit ok, input int et,
                     input int eh, input bit ev, input bit eta, input bit eha, input int ee);
    int rc;
    wait_se(rc);
    answer(s, t, h, ok, et, eh, ev, eta, eha, ee);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({dht_sample_en, temp_out, hum_out, avg_valid, new_sample, temp_alarm,
                            hum_alarm, timeout_err, err_cnt}), 0);
    rst_n = 1'b1;
    // first request left unanswered: warm-up timing, pulse width, timeout
    wait_se(r);
    chk("first_rise_cyc", 32'(r), 101);
    w = 0;
    while (dht_sample_en === 1'b1 && w < 50) begin
      w++;
      @(negedge clk);
    end
    chk("se_width", 32'(w), 4);
    while (cyc < r + 199) @(negedge clk);
    chk("timeout_before", 32'(timeout_err), 0);
    @(negedge clk);
    chk("timeout_set", 32'(timeout_err), 1);
    chk("timeout_err_cnt", 32'(err_cnt), 1);
    wait_se(r);
    chk("second_rise_cyc", 32'(r), 501);
    answer("p1", 20, 40, 1, 20, 40, 0, 0, 0, 1);
    req("p2", 24, 40, 1, 24, 40, 0, 0, 0, 1);
    req("p3", 28, 40, 1, 28, 40, 0, 0, 0, 1);
    req("p4", 24, 40, 1, 24, 40, 1, 0, 0, 1);
    req("p5", 36, 40, 1, 28, 40, 1, 0, 0, 1);
    // drive the averages across the alarm thresholds
    req("p6", 34, 80, 1, 30, 50, 1, 0, 0, 1);
    req("p7", 34, 80, 1, 32, 60, 1, 0, 0, 1);
    req("p8", 34, 80, 1, 34, 70, 1, 0, 0, 1);
    req("p9", 38, 80, 1, 35, 80, 1, 1, 1, 1);
    req("p10", 18, 40, 1, 31, 70, 1, 1, 0, 1);
    req("p11", 30, 40, 1, 30, 60, 1, 0, 0, 1);
    req("p12_rej_t", 60, 40, 0, 30, 60, 1, 0, 0, 2);
    req("p13_edge", 50, 95, 1, 34, 63, 1, 0, 0, 2);
    req("p14_rej_h", 25, 96, 0, 34, 63, 1, 0, 0, 3);
    dht_data_rdy = 1'b1;
    dht_temperature = 8'd10;
    dht_humidity = 8'd10;
    @(negedge clk);
    dht_data_rdy = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (new_sample) seen = 1'b1;
    end
    chk("gap_edge_ignored", 32'(seen), 0);
    chk("gap_temp_hold", 32'(temp_out), 34);
    chk("gap_err_hold", 32'(err_cnt), 3);
    // data edge sampled on the same clock the timeout expires
    wait_se(r);
    while (cyc < r + 199) @(negedge clk);
    dht_data_rdy = 1'b1;
    dht_temperature = 8'd30;
    dht_humidity = 8'd40;
    @(negedge clk);
    dht_data_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("tmo_race_new_sample", 32'(new_sample), 1);
    chk("tmo_race_temp", 32'(temp_out), 32);
    chk("tmo_race_hum", 32'(hum_out), 53);
    chk("tmo_race_timeout_err", 32'(timeout_err), 0);
    chk("tmo_race_err_cnt", 32'(err_cnt), 3);
    // enable dropped while the request pulse is high
    wait_se(r);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_se_low", 32'(dht_sample_en), 0);
    repeat (10) @(negedge clk);
    chk("dis_se_stays_low", 32'(dht_sample_en), 0);
    chk("dis_temp_hold", 32'(temp_out), 32);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable_se", 32'(dht_sample_en), 1);
    // reset while waiting for the answer
    wait_fall();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 32'({dht_sample_en, temp_out, hum_out, avg_valid, new_sample, temp_alarm,
                               hum_alarm, timeout_err, err_cnt}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_se(r);
    chk("post_rst_rise_cyc", 32'(r), 101);
    answer("post_rst", 20, 40, 1, 20, 40, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
